multi_debouncer: RTL

- Parametrised N-channel push-button conditioner for board switches and keys.
- Each channel has a two-flop synchroniser, a polarity-normalised debounce counter, registered press/release strobes, a long-press detector and an optional auto-repeat generator.
- Sits between raw FPGA pins and control logic such as the mode select and start/step buttons of the image-processing controller.
- Channels are fully independent; one instance replaces per-button debounce logic.

---
 rtl/multi_debouncer_if.sv | 30 +++
 rtl/multi_debouncer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/multi_debouncer_if.sv
// multi_debouncer_if: bundles the per-channel button pins, repeat enables and
// the conditioned button events of multi_debouncer.
//   pb_in      raw asynchronous pins               (master -> slave)
//   repeat_en  per-channel auto-repeat enable      (master -> slave)
//   pb_state   debounced level, 1 = pressed        (slave -> master)
//   pb_down    one-cycle press strobe              (slave -> master)
//   pb_up      one-cycle release strobe            (slave -> master)
//   pb_long    one-cycle long-press strobe         (slave -> master)
//   pb_repeat  one-cycle auto-repeat strobe        (slave -> master)
interface multi_debouncer_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] pb_in;
  logic [CHANNELS-1:0] repeat_en;
  logic [CHANNELS-1:0] pb_state;
  logic [CHANNELS-1:0] pb_down;
  logic [CHANNELS-1:0] pb_up;
  logic [CHANNELS-1:0] pb_long;
  logic [CHANNELS-1:0] pb_repeat;

  modport master (
    output pb_in, repeat_en,
    input  pb_state, pb_down, pb_up, pb_long, pb_repeat
  );

  modport slave (
    input  pb_in, repeat_en,
    output pb_state, pb_down, pb_up, pb_long, pb_repeat
  );
endinterface

// File: rtl/multi_debouncer.sv
// multi_debouncer: N independent push-button conditioners. Each channel runs a
// two-flop synchroniser, a debounce counter, registered press/release strobes,
// a long-press detector and an auto-repeat generator.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    multi_debouncer_if.slave (pins and enables in, button events out)
//
// Per-channel FSM:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | button released, hold counter parked at 0
//   PRESSED    | debounced press seen, counting towards the long-press pulse
//   LONG       | long press reported, hold counter paces auto-repeat pulses
module multi_debouncer #(
  parameter int CHANNELS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  multi_debouncer_if.slave bus
);

  localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_TC  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] RPT_TC   = HOLD_W'(REPEAT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  // Normalise polarity up front so everything downstream sees 1 = pressed.
  logic [CHANNELS-1:0] pb_norm;
  assign pb_norm = (ACTIVE_LOW != 0) ? ~bus.pb_in : bus.pb_in;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic              sync0_q, sync0_d;
    logic              sync1_q, sync1_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              level_q, level_d;
    logic              down_q, down_d;
    logic              up_q, up_d;
    logic              long_q, long_d;
    logic              rpt_q, rpt_d;
    logic [1:0]        fsm_q, fsm_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              flip;

    always_comb begin
      sync0_d   = pb_norm[i];
      sync1_d   = sync0_q;
      deb_cnt_d = '0;
      flip      = 1'b0;

      // Any cycle of agreement leaves deb_cnt_d at 0, restarting the count.
      if (sync1_q != level_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          flip = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      level_d = level_q ^ flip;
      down_d  = flip & ~level_q;
      up_d    = flip & level_q;

      fsm_d  = fsm_q;
      hold_d = hold_q;
      long_d = 1'b0;
      rpt_d  = 1'b0;

      // Release takes priority so a threshold hit on the release edge is dropped.
      if (up_d) begin
        fsm_d  = ST_IDLE;
        hold_d = '0;
      end else begin
        case (fsm_q)
          ST_IDLE: begin
            if (down_d) begin
              fsm_d  = ST_PRESSED;
              hold_d = HOLD_ONE;
            end
          end
          ST_PRESSED: begin
            if (hold_q == HOLD_TC) begin
              long_d = 1'b1;
              fsm_d  = ST_LONG;
              hold_d = HOLD_ONE;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          ST_LONG: begin
            // The counter keeps running while repeat is disabled so the
            // repeat phase survives a masked interval.
            if (hold_q == RPT_TC) begin
              hold_d = HOLD_ONE;
              rpt_d  = bus.repeat_en[i];
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          default: begin
            fsm_d  = ST_IDLE;
            hold_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync0_q   <= 1'b0;
        sync1_q   <= 1'b0;
        deb_cnt_q <= '0;
        level_q   <= 1'b0;
        down_q    <= 1'b0;
        up_q      <= 1'b0;
        long_q    <= 1'b0;
        rpt_q     <= 1'b0;
        fsm_q     <= ST_IDLE;
        hold_q    <= '0;
      end else begin
        sync0_q   <= sync0_d;
        sync1_q   <= sync1_d;
        deb_cnt_q <= deb_cnt_d;
        level_q   <= level_d;
        down_q    <= down_d;
        up_q      <= up_d;
        long_q    <= long_d;
        rpt_q     <= rpt_d;
        fsm_q     <= fsm_d;
        hold_q    <= hold_d;
      end
    end

    assign bus.pb_state[i]  = level_q;
    assign bus.pb_down[i]   = down_q;
    assign bus.pb_up[i]     = up_q;
    assign bus.pb_long[i]   = long_q;
    assign bus.pb_repeat[i] = rpt_q;
  end

endmodule
